mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 2, meaning the number of cycles from address presentation to valid mem_rdata (legal range 1..3).
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port fetch_req, input, 1, meaning the instruction-fetch requester wants memory.
REQ-005 SHALL have port fetch_ctrl, input, mem_control_t, meaning the fetch request (addr, wenable, wdata, wwidth).
REQ-006 SHALL have port fetch_gnt, output, 1, meaning the fetch request is accepted this cycle.
REQ-007 SHALL have port fetch_rvalid, output, 1, meaning fetch_rdata is valid this cycle.
REQ-008 SHALL have port fetch_rdata, output, XLEN, meaning the read data returned to fetch.
REQ-009 SHALL have ports data_req, data_ctrl, data_gnt, data_rvalid and data_rdata, identical to REQ-004..008, for the load/store requester.
REQ-010 SHALL have port mem_ctrl, output, mem_control_t, meaning the request driven to the memory.
REQ-011 SHALL have port mem_rdata, input, XLEN, meaning the memory read data.
REQ-012 SHALL have port busy, output, 1, meaning a read is in flight.

Function
REQ-013 SHALL implement two states: IDLE and READ_WAIT.
REQ-014 SHALL, in IDLE with at least one req high, grant exactly one requester combinationally in the same cycle (gnt=1) and drive its ctrl onto mem_ctrl.
REQ-015 SHALL, on a granted write (wenable=1), pass the write to memory for one cycle and remain in IDLE, with no rvalid.
REQ-016 SHALL, on a granted read, latch the owner and addr, set a counter to READ_LATENCY, and enter READ_WAIT.
REQ-017 SHALL, in READ_WAIT, hold mem_ctrl.addr at the latched address with wenable=0, decrement the counter each cycle, and keep both gnt low.
REQ-018 SHALL assert the owner's rvalid for exactly one cycle, READ_LATENCY cycles after the grant cycle, with rdata=mem_rdata, then return to IDLE.
REQ-019 SHALL never grant a request in the cycle rvalid is high; the earliest next grant is the following cycle.
REQ-020 SHALL drive the non-owner's rvalid to 0 at all times, and both rdata outputs to 'X when not valid.
REQ-021 SHALL, in IDLE with no req, drive mem_ctrl.wenable=0 and addr='X.
REQ-022 SHALL require each requester to hold req and ctrl stable until gnt; a req dropped before gnt is ignored with no side effect.
REQ-023 SHALL assert busy exactly while in READ_WAIT.
REQ-024 SHALL, on simultaneous req, resolve according to REQ-028/029.

Reset
REQ-025 SHALL, when reset_n=0 at a clock edge, enter IDLE, clear the counter, and set last_grant=data, making both gnt and rvalid 0 and mem_ctrl.wenable 0.
REQ-026 SHALL, on reset during READ_WAIT, abandon the in-flight read; no rvalid is emitted for it.
REQ-027 SHALL force gnt=0 in every cycle in which reset_n=0.

Configuration
REQ-028 SHALL, with MEM_ARB_ROUND_ROBIN_EN defined, grant the requester not granted most recently on a tie; last_grant updates on every grant, and fetch wins the first tie after reset.
REQ-029 SHALL, without MEM_ARB_ROUND_ROBIN_EN defined, use fixed priority with data over fetch; last_grant is absent.

Structure
REQ-030 SHALL take mem_control_t, the write-width enum and XLEN from package isa_types, and add arb_state_t and arb_port_t (FETCH, DATA) to that package.
REQ-031 SHALL be a single module with no sub-modules; the counter and state live inline.

Verification
REQ-032 Fetch read only, addr 0x10, memory word 0xDEADBEEF: fetch_gnt in cycle 0; fetch_rvalid with 0xDEADBEEF in cycle 2; data_rvalid 0 throughout.
REQ-033 Data write only, SW 0x12345678 to 0x800: data_gnt in cycle 0 with mem_ctrl.wenable=1 and wwidth=write_word; no rvalid; a fetch granted in cycle 1.
REQ-034 Both req high every cycle, all reads: with the macro, grant order is fetch, data, fetch, data with grants 3 cycles apart; without the macro, data wins every time.
REQ-035 Data read of 0x804 issued while fetch req is held: fetch_gnt stays 0 through READ_WAIT and the rvalid cycle, then rises in the cycle after data_rvalid.
REQ-036 reset_n=0 one cycle after a fetch read grant: no fetch_rvalid occurs, busy=0 the cycle after reset, and a new read after release completes normally.
REQ-037 Fetch req pulsed for 1 cycle while data holds READ_WAIT: no fetch grant occurs and mem_ctrl.addr stays at the data address.

Source files
------------

// File: rtl/isa_types.sv
// isa_types: shared memory-interface types for the core.
//   XLEN          - data/address width
//   write_width_t - store width (byte/half/word)
//   mem_control_t - one memory request: addr, wenable, wdata, wwidth
//   arb_state_t   - mem_arbiter FSM states
//   arb_port_t    - mem_arbiter requester identity (FETCH, DATA)
package isa_types;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    write_byte,
    write_half,
    write_word
  } write_width_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            wenable;
    logic [XLEN-1:0] wdata;
    write_width_t    wwidth;
  } mem_control_t;

  typedef enum logic {
    IDLE,
    READ_WAIT
  } arb_state_t;

  typedef enum logic {
    FETCH,
    DATA
  } arb_port_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and load/store.
// Grants are combinational in IDLE; a granted write takes one cycle, a granted
// read holds the port for READ_LATENCY cycles and returns data on the owner's
// rvalid in the last of them.
//
// Parameter:
//   READ_LATENCY - cycles from address presentation to valid mem_rdata (1..3)
// Ports:
//   clock, reset_n                 - clock, synchronous active-low reset
//   fetch_req/ctrl/gnt/rvalid/rdata - instruction-fetch requester
//   data_req/ctrl/gnt/rvalid/rdata  - load/store requester
//   mem_ctrl, mem_rdata            - memory request out, read data in
//   busy                           - a read is in flight
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN - alternate on ties (fetch first after reset);
//                            otherwise data has fixed priority over fetch.
module mem_arbiter
  import isa_types::*;
#(
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            fetch_req,
  input  mem_control_t    fetch_ctrl,
  output logic            fetch_gnt,
  output logic            fetch_rvalid,
  output logic [XLEN-1:0] fetch_rdata,
  input  logic            data_req,
  input  mem_control_t    data_ctrl,
  output logic            data_gnt,
  output logic            data_rvalid,
  output logic [XLEN-1:0] data_rdata,
  output mem_control_t    mem_ctrl,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
);

  arb_state_t      state;
  logic [1:0]      count;
  arb_port_t       owner;
  logic [XLEN-1:0] addr_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_port_t       last_grant;
`endif

  arb_port_t       pick;
  logic            grant_any;
  logic            rvalid_now;
  mem_control_t    sel_ctrl;

  always_comb begin
    pick = DATA;
    if (fetch_req && data_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      pick = (last_grant == DATA) ? FETCH : DATA;
`else
      pick = DATA;
`endif
    end else if (fetch_req) begin
      pick = FETCH;
    end
  end

  assign sel_ctrl   = (pick == FETCH) ? fetch_ctrl : data_ctrl;
  assign grant_any  = reset_n && (state == IDLE) && (fetch_req || data_req);
  assign fetch_gnt  = grant_any && (pick == FETCH);
  assign data_gnt   = grant_any && (pick == DATA);

  // Counter reaches 1 in the READ_LATENCY-th cycle after the grant cycle.
  assign rvalid_now   = reset_n && (state == READ_WAIT) && (count == 2'd1);
  assign fetch_rvalid = rvalid_now && (owner == FETCH);
  assign data_rvalid  = rvalid_now && (owner == DATA);
  assign fetch_rdata  = fetch_rvalid ? mem_rdata : 'x;
  assign data_rdata   = data_rvalid  ? mem_rdata : 'x;
  assign busy         = (state == READ_WAIT);

  always_comb begin
    mem_ctrl         = 'x;
    mem_ctrl.wenable = 1'b0;
    if (state == READ_WAIT) begin
      mem_ctrl.addr = addr_q;
    end else if (grant_any) begin
      mem_ctrl = sel_ctrl;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      count  <= '0;
      owner  <= DATA;
      addr_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant <= DATA;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant <= pick;
`endif
            if (!sel_ctrl.wenable) begin
              state  <= READ_WAIT;
              count  <= 2'(READ_LATENCY);
              owner  <= pick;
              addr_q <= sel_ctrl.addr;
            end
          end
        end
        READ_WAIT: begin
          count <= count - 2'd1;
          if (count == 2'd1) begin
            state <= IDLE;
            count <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter.
// A timeline model predicts grants, busy and the memory request each cycle and
// queues expected read returns; a monitor pops them when an rvalid appears.
// Honors MEM_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_arbiter;
  import isa_types::*;

  localparam int unsigned RL = 2;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset_n;
  logic            fetch_req, data_req;
  mem_control_t    fetch_ctrl, data_ctrl, mem_ctrl;
  logic            fetch_gnt, fetch_rvalid, data_gnt, data_rvalid, busy;
  logic [XLEN-1:0] fetch_rdata, data_rdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = -1;

  typedef struct {
    int          due;
    bit          is_fetch;
    logic [31:0] addr;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign mem_rdata = mem_word(mem_ctrl.addr);

  mem_arbiter #(.READ_LATENCY(RL)) dut (
    .clock(clock), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_ctrl(fetch_ctrl), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_ctrl(data_ctrl), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_ctrl(mem_ctrl), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Timeline model: the port is free from free_at on; a read owns it for
  // RL cycles after its grant cycle, a write only for the grant cycle.
  int          free_at = 0;
  int          bstart = 1, bend = 0;
  bit          last_fetch = 1'b0;
  logic [31:0] read_addr = '0;

  always @(negedge clock) begin
    bit           ef, ed, ebusy;
    mem_control_t gc;
    cyc++;
    ebusy = (cyc >= bstart) && (cyc <= bend);
    ef = 1'b0;
    ed = 1'b0;
    if (reset_n && cyc >= free_at && (fetch_req || data_req)) begin
      if (fetch_req && data_req) ef = RR ? !last_fetch : 1'b0;
      else                       ef = fetch_req;
      ed = !ef;
    end
    check("fetch_gnt", fetch_gnt, ef);
    check("data_gnt", data_gnt, ed);
    check("busy", busy, ebusy);
    if (ef || ed) begin
      gc = ef ? fetch_ctrl : data_ctrl;
      check("grant_addr", mem_ctrl.addr, gc.addr);
      check("grant_wen", mem_ctrl.wenable, gc.wenable);
      last_fetch = ef;
      if (gc.wenable) begin
        check("write_data", mem_ctrl.wdata, gc.wdata);
        check("write_width", mem_ctrl.wwidth, gc.wwidth);
        free_at = cyc + 1;
      end else begin
        sb.push_back('{due: cyc + int'(RL), is_fetch: ef, addr: gc.addr});
        read_addr = gc.addr;
        free_at = cyc + int'(RL) + 1;
        bstart  = cyc + 1;
        bend    = cyc + int'(RL);
      end
    end else if (ebusy && reset_n) begin
      check("hold_addr", mem_ctrl.addr, read_addr);
      check("hold_wen", mem_ctrl.wenable, 1'b0);
    end else begin
      check("idle_wen", mem_ctrl.wenable, 1'b0);
    end
    if (!reset_n) begin
      sb.delete();
      free_at    = cyc + 1;
      bend       = cyc;
      last_fetch = 1'b0;
    end
  end

  always @(negedge clock) begin
    exp_t e;
    #2;
    if (fetch_rvalid || data_rvalid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid cycle %0d: got fetch=%0b data=%0b expected none",
                 cyc, fetch_rvalid, data_rvalid);
      end else begin
        e = sb.pop_front();
        check("rvalid_cycle", cyc, e.due);
        check("rvalid_fetch", fetch_rvalid, e.is_fetch);
        check("rvalid_data", data_rvalid, !e.is_fetch);
        check("rdata", e.is_fetch ? fetch_rdata : data_rdata, mem_word(e.addr));
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_rvalid cycle %0d: got none expected due %0d", cyc, sb[0].due);
      void'(sb.pop_front());
    end
  end

  task automatic new_ctrl(output mem_control_t c, input bit allow_write);
    c.addr    = 32'($urandom_range(0, 4095)) << 2;
    c.wenable = allow_write && ($urandom_range(0, 99) < 30);
    c.wdata   = $urandom;
    c.wwidth  = write_width_t'($urandom_range(0, 2));
  endtask

  // mode 0: random traffic with drops and resets; 1: both always read; 2: idle
  task automatic run_cycles(input int n, input int mode);
    logic fg, dg;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      fg = fetch_gnt;
      dg = data_gnt;
      @(posedge clock);
      #1;
      reset_n = !(mode == 0 && $urandom_range(0, 99) < 2);
      if (mode == 2) begin
        fetch_req = 1'b0;
        data_req  = 1'b0;
      end else begin
        if (fetch_req && !fg && mode == 0 && $urandom_range(0, 99) < 5) begin
          fetch_req = 1'b0;
        end else if (!fetch_req || fg) begin
          fetch_req = (mode == 1) || ($urandom_range(0, 99) < 40);
          new_ctrl(fetch_ctrl, mode == 0);
        end
        if (data_req && !dg && mode == 0 && $urandom_range(0, 99) < 5) begin
          data_req = 1'b0;
        end else if (!data_req || dg) begin
          data_req = (mode == 1) || ($urandom_range(0, 99) < 40);
          new_ctrl(data_ctrl, mode == 0);
        end
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    fetch_req  = 1'b0;
    data_req   = 1'b0;
    fetch_ctrl = '0;
    data_ctrl  = '0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    run_cycles(40, 1);
    run_cycles(3000, 0);
    run_cycles(12, 2);
    @(negedge clock);
    #3;
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
